// File: rtl/audio_sample_mixer_if.sv
// Mixer bus: two stereo PCM sources, gains and mute/clip controls in,
// stereo sample word and status flags out.
interface audio_sample_mixer_if #(
  parameter int IN_WIDTH        = 16,
  parameter int AUDIO_BIT_WIDTH = 16
);
  logic signed [IN_WIDTH-1:0]       src_a_l, src_a_r;
  logic                             src_a_valid;
  logic signed [IN_WIDTH-1:0]       src_b_l, src_b_r;
  logic                             src_b_valid;
  logic [7:0]                       gain_a, gain_b;
  logic                             mute_req;
  logic                             clip_clear;
  logic [1:0][AUDIO_BIT_WIDTH-1:0]  audio_sample_word;
  logic                             muted;
  logic                             clip_l, clip_r;

  // Source / control side.
  modport master (
    output src_a_l, src_a_r, src_a_valid, src_b_l, src_b_r, src_b_valid,
    output gain_a, gain_b, mute_req, clip_clear,
    input  audio_sample_word, muted, clip_l, clip_r
  );

  // Mixer side.
  modport slave (
    input  src_a_l, src_a_r, src_a_valid, src_b_l, src_b_r, src_b_valid,
    input  gain_a, gain_b, mute_req, clip_clear,
    output audio_sample_word, muted, clip_l, clip_r
  );
endinterface

// File: rtl/audio_sample_mixer.sv
// Stereo two-source mixer: per-source Q1.7 gain, soft mute ramp, output
// saturation with sticky clip flags. Three register stages, no stalls.

// One channel of the mix datapath (gain, sum, ramp scale, saturate).
module audio_mix_lane #(
  parameter int IN_WIDTH        = 16,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int RAMP_LOG2       = 6
) (
  input  logic                              clk_audio,
  input  logic                              reset,
  input  logic signed [IN_WIDTH-1:0]        src_a,
  input  logic                              src_a_valid,
  input  logic signed [IN_WIDTH-1:0]        src_b,
  input  logic                              src_b_valid,
  input  logic [7:0]                        gain_a,
  input  logic [7:0]                        gain_b,
  input  logic [RAMP_LOG2:0]                level,
  input  logic                              clip_clear,
  output logic [AUDIO_BIT_WIDTH-1:0]        sample,
  output logic                              clip
);
  localparam int AW  = AUDIO_BIT_WIDTH;
  localparam int PW  = IN_WIDTH + 9;          // source x unsigned 8-bit gain
  localparam int SW  = PW + 1;                // sum of two products
  localparam int MNW = IN_WIDTH + 3;          // sum after the Q1.7 shift
  localparam int MW  = AW + 3;                // aligned to the output width
  localparam int SH  = AW - IN_WIDTH;
  localparam int RW  = MW + RAMP_LOG2 + 2;    // m x level (level as signed)

  logic signed [PW-1:0]  pa_d, pa_q, pb_d, pb_q;
  logic signed [MW-1:0]  m_d, m_q;
  logic [AW-1:0]         out_d, out_q;
  logic                  clip_d, clip_q;
  logic signed [SW-1:0]  sum;
  logic signed [MNW-1:0] m_nat;
  logic signed [RW-1:0]  r;
  logic                  sat;

  // S1: apply per-source gain; an invalid source contributes zero.
  always_comb begin
    pa_d = '0;
    pb_d = '0;
    if (src_a_valid) pa_d = PW'(src_a) * PW'($signed({1'b0, gain_a}));
    if (src_b_valid) pb_d = PW'(src_b) * PW'($signed({1'b0, gain_b}));
  end

  // S2: sum, drop the Q1.7 fraction (floor), align to the output width.
  always_comb begin
    sum   = SW'(pa_q) + SW'(pb_q);
    m_nat = MNW'(sum >>> 7);
    m_d   = MW'(m_nat) <<< SH;
  end

  // S3: scale by the ramp level, saturate, and update the sticky clip flag.
  // The level used is the one the mute FSM registers on this same edge, so
  // the sample leaving the pipeline always matches the muted flag beside it.
  always_comb begin
    r     = (RW'(m_q) * RW'($signed({1'b0, level}))) >>> RAMP_LOG2;
    sat   = !((&r[RW-1:AW-1]) || !(|r[RW-1:AW-1]));
    out_d = r[AW-1:0];
    if (sat) out_d = r[RW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    clip_d = sat | (clip_q & ~clip_clear);
  end

  // Pipeline and flag registers.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      pa_q   <= '0;
      pb_q   <= '0;
      m_q    <= '0;
      out_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      m_q    <= m_d;
      out_q  <= out_d;
      clip_q <= clip_d;
    end
  end

  assign sample = out_q;
  assign clip   = clip_q;
endmodule

module audio_sample_mixer #(
  parameter int IN_WIDTH        = 16,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int RAMP_LOG2       = 6
) (
  input logic                 clk_audio,
  input logic                 reset,
  audio_sample_mixer_if.slave mix
);
  localparam int LW = RAMP_LOG2 + 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(1 << RAMP_LOG2);

  typedef enum logic [1:0] {
    S_MUTED,
    S_RAMP_UP,
    S_UNMUTED,
    S_RAMP_DOWN
  } mute_state_e;

  mute_state_e   state_d, state_q;
  logic [LW-1:0] level_d, level_q;
  logic          muted_d, muted_q;

  logic [1:0][IN_WIDTH-1:0]        a_ch, b_ch;
  logic [1:0][AUDIO_BIT_WIDTH-1:0] word;
  logic [1:0]                      clip;

  // Mute ramp: one level step per cycle. Leaving a rest state steps at once;
  // a reversal mid-ramp spends its cycle turning around, so the level never jumps.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      S_MUTED: begin
        if (!mix.mute_req) begin
          state_d = S_RAMP_UP;
          level_d = level_q + 1'b1;
        end
      end
      S_RAMP_UP: begin
        if (mix.mute_req) begin
          state_d = S_RAMP_DOWN;
        end else begin
          level_d = level_q + 1'b1;
          if (level_d == LVL_MAX) state_d = S_UNMUTED;
        end
      end
      S_UNMUTED: begin
        if (mix.mute_req) begin
          state_d = S_RAMP_DOWN;
          level_d = level_q - 1'b1;
        end
      end
      S_RAMP_DOWN: begin
        if (!mix.mute_req) begin
          state_d = S_RAMP_UP;
        end else begin
          level_d = level_q - 1'b1;
          if (level_d == '0) state_d = S_MUTED;
        end
      end
      default: begin
        state_d = S_MUTED;
        level_d = '0;
      end
    endcase
    muted_d = (state_d == S_MUTED);
  end

  // Mute state, level and muted flag registers.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state_q <= S_MUTED;
      level_q <= '0;
      muted_q <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      muted_q <= muted_d;
    end
  end

  assign a_ch = {mix.src_a_r, mix.src_a_l};
  assign b_ch = {mix.src_b_r, mix.src_b_l};

  for (genvar ch = 0; ch < 2; ch++) begin : g_lane
    audio_mix_lane #(
      .IN_WIDTH       (IN_WIDTH),
      .AUDIO_BIT_WIDTH(AUDIO_BIT_WIDTH),
      .RAMP_LOG2      (RAMP_LOG2)
    ) u_lane (
      .clk_audio  (clk_audio),
      .reset      (reset),
      .src_a      (a_ch[ch]),
      .src_a_valid(mix.src_a_valid),
      .src_b      (b_ch[ch]),
      .src_b_valid(mix.src_b_valid),
      .gain_a     (mix.gain_a),
      .gain_b     (mix.gain_b),
      .level      (level_d),
      .clip_clear (mix.clip_clear),
      .sample     (word[ch]),
      .clip       (clip[ch])
    );
  end

  assign mix.audio_sample_word = word;
  assign mix.muted             = muted_q;
  assign mix.clip_l            = clip[0];
  assign mix.clip_r            = clip[1];
endmodule

// File: tb/tb_audio_sample_mixer.sv
// Directed bench for audio_sample_mixer with an arithmetic reference model
// checked every cycle, plus hand-computed spot values.
module tb_audio_sample_mixer;
  localparam int IW = 16;
  localparam int AW = 16;
  localparam int RL = 4;
  localparam int LMAX = 16;

  logic clk = 1'b0;
  logic reset;

  audio_sample_mixer_if #(.IN_WIDTH(IW), .AUDIO_BIT_WIDTH(AW)) bus ();

  audio_sample_mixer #(.IN_WIDTH(IW), .AUDIO_BIT_WIDTH(AW), .RAMP_LOG2(RL)) dut (
    .clk_audio(clk),
    .reset    (reset),
    .mix      (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int al, ar, bl, br, ga, gb;
    bit av, bv;
  } smp_t;

  smp_t h [3];
  int   m_lvl, m_dir, e_l, e_r;
  bit   e_cl, e_cr, e_mu;
  bit   chk_en = 1'b0;

  // Mix one channel straight from the arithmetic definition (floor shifts).
  function automatic int pre_sat(int a, int b, bit av, bit bv, int ga, int gb, int lvl);
    int s;
    s = (av ? a * ga : 0) + (bv ? b * gb : 0);
    s = s >>> 7;
    return (s * lvl) >>> RL;
  endfunction

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk) begin
    int want, rl, rr;
    if (reset) begin
      for (int i = 0; i < 3; i++) h[i] = '{default: 0};
      m_lvl = 0; m_dir = 0;
      e_l = 0; e_r = 0; e_cl = 0; e_cr = 0; e_mu = 1;
      chk_en = 1'b1;
    end else begin
      h[2] = h[1];
      h[1] = h[0];
      h[0].al = bus.src_a_l; h[0].ar = bus.src_a_r;
      h[0].bl = bus.src_b_l; h[0].br = bus.src_b_r;
      h[0].ga = bus.gain_a;  h[0].gb = bus.gain_b;
      h[0].av = bus.src_a_valid; h[0].bv = bus.src_b_valid;
      // level: rest at 0 or LMAX, move toward the request, turning costs a cycle
      want = bus.mute_req ? -1 : 1;
      if (m_dir == 0) begin
        if ((m_lvl == 0 && want > 0) || (m_lvl == LMAX && want < 0)) begin
          m_dir = want;
          m_lvl += want;
        end
      end else if (want != m_dir) begin
        m_dir = want;
      end else begin
        m_lvl += want;
      end
      if (m_lvl == 0 || m_lvl == LMAX) m_dir = 0;
      rl = pre_sat(h[2].al, h[2].bl, h[2].av, h[2].bv, h[2].ga, h[2].gb, m_lvl);
      rr = pre_sat(h[2].ar, h[2].br, h[2].av, h[2].bv, h[2].ga, h[2].gb, m_lvl);
      e_l = sat(rl);
      e_r = sat(rr);
      e_cl = (rl != e_l) ? 1'b1 : (bus.clip_clear ? 1'b0 : e_cl);
      e_cr = (rr != e_r) ? 1'b1 : (bus.clip_clear ? 1'b0 : e_cr);
      e_mu = (m_lvl == 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_left",  $signed(bus.audio_sample_word[0]), e_l);
      check("model_right", $signed(bus.audio_sample_word[1]), e_r);
      check("model_muted", int'(bus.muted), int'(e_mu));
      check("model_clip_l", int'(bus.clip_l), int'(e_cl));
      check("model_clip_r", int'(bus.clip_r), int'(e_cr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int al, input int ar, input int bl, input int br,
                         input bit av, input bit bv, input int ga, input int gb);
    bus.src_a_l = IW'(al); bus.src_a_r = IW'(ar);
    bus.src_b_l = IW'(bl); bus.src_b_r = IW'(br);
    bus.src_a_valid = av;  bus.src_b_valid = bv;
    bus.gain_a = 8'(ga);   bus.gain_b = 8'(gb);
  endtask

  function automatic int left();
    return $signed(bus.audio_sample_word[0]);
  endfunction

  function automatic int right();
    return $signed(bus.audio_sample_word[1]);
  endfunction

  initial begin
    reset = 1'b1;
    bus.mute_req = 1'b0;
    bus.clip_clear = 1'b0;
    set_src(0, 0, 0, 0, 0, 0, 0, 0);
    tick(2);
    check("reset_left", left(), 0);
    check("reset_right", right(), 0);
    check("reset_muted", int'(bus.muted), 1);
    check("reset_clips", int'({bus.clip_l, bus.clip_r}), 0);

    // 1: ramp up, unity gain on A, B invalid
    set_src(1000, -1000, 0, 0, 1, 0, 128, 0);
    reset = 1'b0;
    tick(16);
    tick(3);
    check("t1_left", left(), 1000);
    check("t1_right", right(), -1000);
    check("t1_muted", int'(bus.muted), 0);

    // 2: saturation and sticky clip behaviour
    set_src(30000, 0, 30000, 0, 1, 1, 128, 128);
    tick(3);
    check("t2_sat_left", left(), 32767);
    check("t2_clip_l", int'(bus.clip_l), 1);
    check("t2_clip_r_quiet", int'(bus.clip_r), 0);
    set_src(0, 0, 0, 0, 1, 1, 128, 128);
    tick(3);
    check("t2_clip_sticky", int'(bus.clip_l), 1);
    bus.clip_clear = 1'b1;
    tick(1);
    bus.clip_clear = 1'b0;
    check("t2_clip_cleared", int'(bus.clip_l), 0);
    set_src(30000, 0, 30000, 0, 1, 1, 128, 128);
    tick(2);
    bus.clip_clear = 1'b1;
    tick(1);
    bus.clip_clear = 1'b0;
    check("t2_set_wins", int'(bus.clip_l), 1);
    set_src(0, -30000, 0, -30000, 1, 1, 128, 128);
    tick(3);
    check("t2_sat_right_neg", right(), -32768);
    check("t2_clip_r", int'(bus.clip_r), 1);
    set_src(0, 0, 0, 0, 1, 1, 128, 128);
    tick(3);
    bus.clip_clear = 1'b1;
    tick(1);
    bus.clip_clear = 1'b0;
    check("t2_both_cleared", int'({bus.clip_l, bus.clip_r}), 0);

    // 3: ramp down from unmuted with steady 16000
    set_src(16000, 16000, 0, 0, 1, 0, 128, 0);
    tick(3);
    check("t3_steady", left(), 16000);
    bus.mute_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      check("t3_ramp_left", left(), 16000 - 1000 * i);
      check("t3_ramp_muted", int'(bus.muted), (i == 16) ? 1 : 0);
    end

    // 4: reverse a ramp down at level 8
    bus.mute_req = 1'b0;
    tick(16);
    check("t4_full", left(), 16000);
    bus.mute_req = 1'b1;
    tick(8);
    check("t4_level8", left(), 8000);
    bus.mute_req = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick(1);
      check("t4_reverse_left", left(), 1000 * ((j == 1) ? 8 : 7 + j));
      check("t4_reverse_muted", int'(bus.muted), 0);
    end

    // 5: reset in the middle of a ramp up, with a clip pending
    set_src(16000, 16000, 30000, 0, 1, 1, 128, 128);
    tick(3);
    check("t5_clip_pre", int'(bus.clip_l), 1);
    set_src(16000, 16000, 0, 0, 1, 0, 128, 0);
    bus.mute_req = 1'b1;
    tick(16);
    check("t5_muted", int'(bus.muted), 1);
    bus.mute_req = 1'b0;
    tick(10);
    check("t5_level10", left(), 10000);
    reset = 1'b1;
    tick(1);
    check("t5_rst_muted", int'(bus.muted), 1);
    check("t5_rst_out", int'(bus.audio_sample_word), 0);
    check("t5_rst_clips", int'({bus.clip_l, bus.clip_r}), 0);
    reset = 1'b0;
    tick(1);
    check("t5_restart_muted", int'(bus.muted), 0);
    check("t5_restart_out", left(), 0);
    tick(2);
    check("t5_restart_lvl3", left(), 3000);

    // 6: fractional gain floor, invalid sources, source B path, full scale
    tick(13);
    check("t6_unmuted", left(), 16000);
    set_src(-4, -3, 0, 0, 1, 0, 64, 0);
    tick(3);
    check("t6_floor_m4", left(), -2);
    check("t6_floor_m3", right(), -2);
    set_src(-4, -3, 0, 0, 0, 0, 64, 0);
    tick(3);
    check("t6_invalid_l", left(), 0);
    check("t6_invalid_r", right(), 0);
    set_src(0, 0, 100, -100, 0, 1, 0, 200);
    tick(3);
    check("t6_b_left", left(), 156);
    check("t6_b_right", right(), -157);
    set_src(-32768, 32767, -32768, 32767, 1, 1, 255, 255);
    tick(3);
    check("t6_fs_left", left(), -32768);
    check("t6_fs_right", right(), 32767);
    check("t6_fs_clips", int'({bus.clip_l, bus.clip_r}), 3);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
